lcd_refresh_sequencer: RTL
==========================

# lcd_refresh_sequencer

Character-buffer front end for the HD44780-style LCD controller. Holds a 2-line × COLS-column shadow of the display. Host logic writes this shadow with single-cycle writes. The block tracks which lines are dirty and sequences the controller's one-command-at-a-time port to redraw them: a set-DDRAM-address command followed by COLS character writes. It is the only driver of the controller's `lcd_enable`/`lcd_bus` inputs.

## Interface
Parameters:
- `COLS`, 16, characters per line (2..16)
- `LINE0_ADDR`, 8'h00, DDRAM base address of line 0
- `LINE1_ADDR`, 8'h40, DDRAM base address of line 1
- `BUSY_TO`, 4, cycles to wait for `lcd_busy` to rise after a command before proceeding anyway

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `wr_en`  in  1  host write strobe, one write per cycle
- `wr_line`  in  1  target line
- `wr_col`  in  4  target column; writes with `wr_col >= COLS` are ignored
- `wr_char`  in  8  character code
- `refresh_req`  in  1  pulse; marks both lines dirty
- `lcd_busy`  in  1  controller busy
- `lcd_enable`  out  1  one-cycle command strobe to controller
- `lcd_bus`  out  10  {rs, rw, data[7:0]} presented with `lcd_enable`
- `dirty`  out  2  per-line dirty flags
- `idle`  out  1  high in IDLE with no dirty line

## Operation
- Buffer is registered storage, 2×COLS×8. Reset fills it with 8'h20 (space) and sets `dirty`=2'b11, so the first action after reset is a blank redraw.
- Host write: updates the cell at the next edge and sets `dirty[wr_line]`. The write is accepted in any state.
- Commands:
  - Set-address is `{1'b0,1'b0, 8'h80 | base}`.
  - Character write is `{1'b1,1'b0, buf[line][col]}`.
  - `rw` is always 0.
- FSM states: IDLE, ISSUE, WAIT_HI, WAIT_LO.
  - IDLE: if any dirty bit is set, select a line, clear `col`, set phase=ADDR, go to ISSUE. Otherwise stay.
  - Line selection is round-robin. When both lines are dirty, take the line not served last. `last` resets to 1, so line 0 goes first after reset.
  - ISSUE: when `lcd_busy`=0, pulse `lcd_enable` for exactly one cycle with the command on `lcd_bus`, then go to WAIT_HI. While `lcd_busy`=1, hold with `lcd_enable`=0.
  - ISSUE with phase=ADDR also clears `dirty[line]` on the same edge as the strobe.
  - ISSUE with phase=CHAR samples `buf[line][col]` on the strobe cycle. A host write to that same cell in that cycle is not reflected, but it re-sets `dirty`.
  - WAIT_HI: go to WAIT_LO when `lcd_busy`=1 is seen, or after `BUSY_TO` cycles without it (timeout).
  - WAIT_LO: when `lcd_busy`=0, advance:
    - ADDR → CHAR with `col`=0, then ISSUE.
    - CHAR with `col`<COLS-1 → `col`+1, then ISSUE.
    - CHAR with `col`=COLS-1 → set `last`=line, go to IDLE.
- Simultaneous events:
  - Dirty set (host write or `refresh_req`) wins over the ADDR-issue clear in the same cycle.
  - A write to the line being redrawn re-marks it dirty, so it is redrawn again after the current pass.
- `lcd_bus` holds its last value when `lcd_enable`=0. It is only meaningful while `lcd_enable`=1.
- Reset mid-redraw:
  - Abandons the sequence immediately, with `lcd_enable`=0 on the next cycle.
  - Re-blanks the buffer and restarts from IDLE with `dirty`=2'b11.
  - No partial command is reissued.

## Timing
- Reset values:
  - `lcd_enable`=0, `lcd_bus`=10'h000
  - `dirty`=2'b11
  - `idle`=0, because dirty is set
  - state IDLE, `col`=0, `last`=1
- All outputs are registered.
- Latency: a host write in cycle t when idle gives `dirty` high in t+1. The earliest `lcd_enable` is in t+3 (IDLE decision in t+1, ISSUE in t+2, strobe registered out in t+3), given `lcd_busy`=0.
- Back-to-back commands are separated by at least the controller busy window plus 2 cycles.
- A line redraw is exactly 1+COLS strobes. `lcd_enable` is never high on two consecutive cycles.
- `lcd_enable` is never asserted in a cycle where the sampled `lcd_busy` was 1.

## Test plan
- Reset, controller model with 5-cycle busy:
  - Expect 34 strobes: 0x080, then 16× 0x220, then 0x0C0, then 16× 0x220.
  - Then `idle`=1 and `dirty`=00.
- Idle; write line1 col3 = 0x41:
  - Expect `dirty`=10.
  - Expect 17 strobes: 0x0C0, then 3× 0x220, then 0x241, then 12× 0x220.
- During line-0 redraw at col 8, write line0 col2 = 0x5A:
  - The current pass completes with old col2.
  - `dirty[0]` remains 1 and a second line-0 pass sends 0x25A at position 2.
- Both lines dirty, `last`=0:
  - Line 1 is served first (0x0C0 before 0x080).
  - `refresh_req` in the ADDR-issue cycle leaves the dirty bit set.
- `lcd_busy` tied 0:
  - Each command takes 1 strobe + `BUSY_TO`-cycle timeout + return to ISSUE.
  - The full line still completes with 17 strobes.
- Assert `rst_n`=0 for 1 cycle at strobe 9 of a redraw:
  - `lcd_enable`=0 next cycle, `dirty`=11.
  - Redraw restarts with 0x080 and blanks.

Source files
------------

// File: rtl/lcd_refresh_sequencer.sv
// Two-line character shadow for an HD44780-style controller. Tracks dirty
// lines and redraws each as one set-DDRAM-address command plus COLS
// character writes, one handshaked command at a time.
module lcd_refresh_sequencer #(
  parameter int unsigned COLS       = 16,
  parameter logic [7:0]  LINE0_ADDR = 8'h00,
  parameter logic [7:0]  LINE1_ADDR = 8'h40,
  parameter int unsigned BUSY_TO    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic       wr_line,
  input  logic [3:0] wr_col,
  input  logic [7:0] wr_char,
  input  logic       refresh_req,
  input  logic       lcd_busy,
  output logic       lcd_enable,
  output logic [9:0] lcd_bus,
  output logic [1:0] dirty,
  output logic       idle
);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitHi, StWaitLo} state_e;

  state_e      state_q, state_d;
  logic        line_q, line_d;
  logic [3:0]  col_q, col_d;
  logic        phase_q, phase_d;   // 0: address command, 1: character writes
  logic        last_q, last_d;     // line served by the most recent full pass
  logic [1:0]  dirty_q, dirty_d;
  logic [7:0]  to_cnt_q, to_cnt_d;
  logic        enable_d;
  logic [9:0]  bus_d;
  logic        idle_d;
  logic [7:0]  cells_q [2][COLS];
  logic [7:0]  cell_rd;
  logic        wr_ok;

  assign dirty = dirty_q;

  // Read mux for the cell being sent, and range check for host writes.
  always_comb begin
    cell_rd = 8'h20;
    wr_ok   = 1'b0;
    for (int c = 0; c < COLS; c++) begin
      if (col_q == 4'(c)) cell_rd = cells_q[line_q][c];
      if (wr_col == 4'(c)) wr_ok = 1'b1;
    end
  end

  // Shadow buffer: reset to spaces, single host write per cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int l = 0; l < 2; l++) begin
        for (int c = 0; c < COLS; c++) cells_q[l][c] <= 8'h20;
      end
    end else if (wr_en) begin
      for (int c = 0; c < COLS; c++) begin
        if (wr_col == 4'(c)) cells_q[wr_line][c] <= wr_char;
      end
    end
  end

  // Next-state, command generation and dirty tracking.
  always_comb begin
    state_d  = state_q;
    line_d   = line_q;
    col_d    = col_q;
    phase_d  = phase_q;
    last_d   = last_q;
    dirty_d  = dirty_q;
    to_cnt_d = to_cnt_q;
    enable_d = 1'b0;
    bus_d    = lcd_bus;
    case (state_q)
      StIdle: begin
        if (|dirty_q) begin
          // Both dirty: alternate; otherwise take whichever is dirty.
          line_d  = (dirty_q == 2'b11) ? ~last_q : dirty_q[1];
          col_d   = 4'd0;
          phase_d = 1'b0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (!lcd_busy) begin
          enable_d = 1'b1;
          if (phase_q) begin
            bus_d = {2'b10, cell_rd};
          end else begin
            bus_d = {2'b00, 8'h80 | (line_q ? LINE1_ADDR : LINE0_ADDR)};
            dirty_d[line_q] = 1'b0;
          end
          to_cnt_d = 8'd0;
          state_d  = StWaitHi;
        end
      end
      StWaitHi: begin
        if (lcd_busy || to_cnt_q == 8'(BUSY_TO - 1)) begin
          state_d = StWaitLo;
        end else begin
          to_cnt_d = to_cnt_q + 8'd1;
        end
      end
      StWaitLo: begin
        if (!lcd_busy) begin
          if (!phase_q) begin
            phase_d = 1'b1;
            col_d   = 4'd0;
            state_d = StIssue;
          end else if (col_q == 4'(COLS - 1)) begin
            last_d  = line_q;
            state_d = StIdle;
          end else begin
            col_d   = col_q + 4'd1;
            state_d = StIssue;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // New dirt overrides the address-issue clear above.
    if (refresh_req) dirty_d = 2'b11;
    if (wr_en && wr_ok) dirty_d[wr_line] = 1'b1;
    idle_d = (state_d == StIdle) && (dirty_d == 2'b00);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      line_q     <= 1'b0;
      col_q      <= 4'd0;
      phase_q    <= 1'b0;
      last_q     <= 1'b1;
      dirty_q    <= 2'b11;
      to_cnt_q   <= 8'd0;
      lcd_enable <= 1'b0;
      lcd_bus    <= 10'h000;
      idle       <= 1'b0;
    end else begin
      state_q    <= state_d;
      line_q     <= line_d;
      col_q      <= col_d;
      phase_q    <= phase_d;
      last_q     <= last_d;
      dirty_q    <= dirty_d;
      to_cnt_q   <= to_cnt_d;
      lcd_enable <= enable_d;
      lcd_bus    <= bus_d;
      idle       <= idle_d;
    end
  end

endmodule
